// File: rtl/park_system_multi.sv
// Multi-floor parking controller: per-floor occupancy, lowest-free-floor
// assignment, and a grant/open/clear entry gate sequence.
module park_system_multi #(
  parameter int N_FLOORS         = 3,
  parameter int SPOTS_PER_FLOOR  = 4,
  parameter int GATE_OPEN_CYCLES = 4,
  localparam int FW = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1,
  localparam int SW = $clog2(SPOTS_PER_FLOOR + 1),
  localparam int CW = $clog2(N_FLOORS * SPOTS_PER_FLOOR + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   car_in,
  input  logic                   car_out,
  input  logic [FW-1:0]          out_floor,
  output logic                   entry_grant,
  output logic [FW-1:0]          entry_floor,
  output logic                   gate_open,
  output logic                   entry_denied,
  output logic [N_FLOORS*SW-1:0] floor_free,
  output logic [CW-1:0]          free_spot,
  output logic                   parking_full,
  output logic                   err_exit
);

  localparam int GCW = $clog2(GATE_OPEN_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_OPEN, S_CLEAR} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [GCW-1:0]       r_gcnt;
  logic [SW-1:0]        r_occ [N_FLOORS];
  logic                 r_err_exit;
  logic [FW-1:0]        r_entry_floor;

  logic [N_FLOORS-1:0]    w_inc;
  logic [N_FLOORS-1:0]    w_dec;
  logic [FW-1:0]          w_sel_floor;
  logic                   w_take;
  logic                   w_exit_bad;
  logic                   w_full;
  logic [CW-1:0]          w_free_total;
  logic [N_FLOORS*SW-1:0] w_floor_free;

  // Free counts and lowest non-full floor, all from registered occupancy
  always_comb begin
    w_floor_free = '0;
    w_free_total = '0;
    w_sel_floor  = '0;
    for (int k = N_FLOORS - 1; k >= 0; k--) begin
      w_floor_free[k*SW +: SW] = SW'(SPOTS_PER_FLOOR) - r_occ[k];
      w_free_total = w_free_total + CW'(w_floor_free[k*SW +: SW]);
      if (r_occ[k] != SW'(SPOTS_PER_FLOOR)) w_sel_floor = FW'(k);
    end
    w_full = (w_free_total == '0);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (car_in && !w_full) begin
          w_take      = 1'b1;
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: w_state_nxt = (GATE_OPEN_CYCLES > 1) ? S_OPEN : S_CLEAR;
      // The GRANT cycle already counts as one open cycle
      S_OPEN:  if (int'(r_gcnt) + 2 >= GATE_OPEN_CYCLES) w_state_nxt = S_CLEAR;
      S_CLEAR: if (!car_in) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Exit matching by comparison avoids indexing occupancy with an out-of-range floor
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int k = 0; k < N_FLOORS; k++) begin
      if (w_take && w_sel_floor == FW'(k)) w_inc[k] = 1'b1;
      if (car_out && out_floor == FW'(k) && r_occ[k] != '0) w_dec[k] = 1'b1;
    end
    w_exit_bad = car_out && (w_dec == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_gcnt        <= '0;
      r_err_exit    <= 1'b0;
      r_entry_floor <= '0;
      for (int k = 0; k < N_FLOORS; k++) r_occ[k] <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gcnt     <= (r_state == S_OPEN) ? r_gcnt + 1'b1 : '0;
      r_err_exit <= w_exit_bad;
      if (w_take) r_entry_floor <= w_sel_floor;
      for (int k = 0; k < N_FLOORS; k++) begin
        if (w_inc[k] && !w_dec[k])      r_occ[k] <= r_occ[k] + 1'b1;
        else if (w_dec[k] && !w_inc[k]) r_occ[k] <= r_occ[k] - 1'b1;
      end
    end
  end

  assign entry_grant  = (r_state == S_GRANT);
  assign gate_open    = (r_state == S_GRANT) || (r_state == S_OPEN);
  assign entry_denied = (r_state == S_IDLE) && car_in && w_full;
  assign entry_floor  = r_entry_floor;
  assign floor_free   = w_floor_free;
  assign free_spot    = w_free_total;
  assign parking_full = w_full;
  assign err_exit     = r_err_exit;

endmodule

// File: doc/park_system_multi.md
# park_system_multi

Parametrised multi-floor parking controller, the next generation of the single-lot `PARK_SYSTEM`. It tracks occupancy per floor and assigns each entering car to the lowest floor with a free spot. It sequences the entry gate through a grant/open/clear handshake and accepts floor-tagged exits. It sits between the gate sensors and the display/barrier drivers of the parking subsystem.

## Interface
Parameters:
- `N_FLOORS`, default 3: number of floors; must be ≥1.
- `SPOTS_PER_FLOOR`, default 4: capacity of each floor; must be ≥1.
- `GATE_OPEN_CYCLES`, default 4: number of cycles the barrier is held open per granted entry; must be ≥1.
- Derived: `FW` = max(1, clog2(`N_FLOORS`)); `SW` = clog2(`SPOTS_PER_FLOOR`+1); `CW` = clog2(`N_FLOORS`*`SPOTS_PER_FLOOR`+1).

Ports:
- `clk`, input, 1: the single clock; everything is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `car_in`, input, 1: entry request (level); held high by the sensor until the car has cleared the gate.
- `car_out`, input, 1: exit event; a single-cycle pulse.
- `out_floor`, input, `FW`: floor of the exiting car; sampled only when `car_out`=1.
- `entry_grant`, output, 1: one-cycle pulse when an entry is accepted.
- `entry_floor`, output, `FW`: floor assigned to the accepted entry; held until the next grant.
- `gate_open`, output, 1: barrier drive.
- `entry_denied`, output, 1: high while a request is pending in IDLE and the lot is full.
- `floor_free`, output, `N_FLOORS`*`SW`: free spots per floor, packed; floor k occupies bits [k*SW +: SW].
- `free_spot`, output, `CW`: total free spots.
- `parking_full`, output, 1: high when `free_spot`==0.
- `err_exit`, output, 1: one-cycle pulse on an illegal exit.

## Operation
- Per-floor occupancy counters `occ[k]`, range 0..`SPOTS_PER_FLOOR`.
- `floor_free[k]` = `SPOTS_PER_FLOOR` − `occ[k]`.
- `free_spot` = sum of `floor_free`.
- All outputs are combinational from registered counts; no arithmetic wraps.
- Entry FSM:
  - IDLE: if `car_in` & !`parking_full`, go to GRANT. If `car_in` & `parking_full`, stay in IDLE with `entry_denied`=1.
  - GRANT (1 cycle): `entry_grant`=1, `gate_open`=1. Go to OPEN.
  - OPEN: `gate_open`=1 for `GATE_OPEN_CYCLES` cycles, counting the GRANT cycle. Then go to CLEAR.
  - CLEAR: `gate_open`=0. Wait for `car_in`=0, then go to IDLE.
  - No new grant is possible until `car_in` has dropped.
- Floor selection:
  - Assigned floor is the lowest index k with `occ[k]` < `SPOTS_PER_FLOOR`, evaluated from the counts in the IDLE cycle.
  - `occ[k]` increments on the edge entering GRANT.
  - `entry_floor` loads on that same edge.
- Exit:
  - When `car_out`=1 and `out_floor` < `N_FLOORS` and `occ[out_floor]` > 0, `occ[out_floor]` decrements.
  - If `out_floor` ≥ `N_FLOORS` or `occ[out_floor]`==0: no count change, and `err_exit`=1 in the following cycle.
  - Exits are processed in every FSM state.
- Simultaneous increment and decrement on the same floor on the same edge: both apply, net count is unchanged.
- Full decision uses pre-edge counts. A request in the same cycle as an exit from a full lot is therefore denied that cycle and granted on the next.

## Timing
- Reset values: state IDLE; all `occ`=0; `free_spot`=`N_FLOORS`*`SPOTS_PER_FLOOR`; every `floor_free` field = `SPOTS_PER_FLOOR`; `parking_full`=0; `entry_grant`=`gate_open`=`entry_denied`=`err_exit`=0; `entry_floor`=0.
- Reset asserted mid-sequence: on the next edge all counts clear and the FSM returns to IDLE. A `car_in` still held high after reset is treated as a new request.
- Latency:
  - `car_in` high at cycle t (IDLE, not full) gives `entry_grant` at t+1.
  - The count update is visible on `free_spot` at t+1.
  - `gate_open` is high for cycles t+1 .. t+`GATE_OPEN_CYCLES`.
- Exit latency: `car_out` at cycle t gives the updated counts at t+1; `err_exit`, if any, is at t+1.
- `entry_denied` is combinational: IDLE & `car_in` & `parking_full`.

## Test plan
- Reset, then defaults (3x4): `free_spot`=12, every `floor_free` field=4, `parking_full`=0, all pulse outputs 0.
- Five back-to-back entries, each holding `car_in` for 6 cycles → grants on floors 0,0,0,0,1; `free_spot`=7; `gate_open` high for exactly 4 cycles per grant.
- Fill to 12 → `parking_full`=1. Further `car_in` → `entry_denied`=1 and no grant. Then `car_out` with `out_floor`=1 → `free_spot`=1, and the next grant assigns floor 1.
- `car_out` with `out_floor`=2 while floor 2 is empty, and `car_out` with `out_floor`=3 → `err_exit` pulse each time; counts unchanged.
- Grant to floor 0 on the same edge as an exit from floor 0 (floor 0 at 2) → `occ[0]` stays 2; `free_spot` unchanged.
- `rst` asserted during OPEN with 6 cars parked → next cycle `free_spot`=12, `gate_open`=0, state IDLE.
